ifu_fetch_gen: RTL and testbench
================================

# ifu_fetch_gen

Parametrised instruction-fetch unit. It generates the fetch PC, issues requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small fetch queue. It hands {pc, instr} pairs to the instruction decoders. Control-flow redirects (conditional branch, JAL, JALR) from execute flush the queue and discard in-flight responses.

## Interface
- XLEN, 32, PC/address width
- RESET_VECTOR, 0, first fetch address after reset (must be 4-byte aligned)
- FQ_DEPTH, 2, fetch-queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sb_type  in  1  conditional branch resolved this cycle
- br_taken  in  1  branch outcome; qualifies sb_type
- uj_type  in  1  JAL resolved this cycle
- i_typej  in  1  JALR resolved this cycle
- ex_pc  in  XLEN  PC of the resolving instruction (base for sb/uj)
- iop_a  in  XLEN  rs1 value (base for JALR)
- imm  in  XLEN  sign-extended halfword offset; byte offset = imm<<1
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  instruction returned (in request order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  decoder-side entry available
- if_ready  in  1  decoder consumes entry
- if_pc  out  XLEN  PC of head entry
- if_instr  out  32  instruction of head entry
- misalign_o  out  1  one-cycle pulse: redirect target not word aligned

## Operation
- Reset: fetch_pc=RESET_VECTOR, queue empty, state REQ, drop flag clear. All outputs 0 except imem_req_addr=RESET_VECTOR. imem_req_valid=0 while rst_n low.
- FSM states:
  - REQ: imem_req_valid=1 when credit>0. Credit = FQ_DEPTH − occupancy − outstanding.
    - REQ→WAIT on valid&ready; fetch_pc += 4 (wraps modulo 2^XLEN).
  - WAIT: no request. At most one request is outstanding.
    - WAIT→REQ on imem_rsp_valid. The response is written to the queue tail with its address, unless the drop flag is set; in that case it is discarded and the flag cleared.
- Redirect target and priority (one per cycle):
  - i_typej: (iop_a + (imm<<1)) & ~1. Highest priority.
  - uj_type: ex_pc + (imm<<1).
  - sb_type&br_taken: ex_pc + (imm<<1). Lowest priority.
  - sb_type with br_taken=0: no effect.
- Valid redirect, target[1:0]==0:
  - Queue flushed; fetch_pc=target; state REQ.
  - If in WAIT with no response this cycle: drop flag set, state stays WAIT.
  - A response arriving in the redirect cycle is discarded.
- Misaligned target (bit 1 set after masking): misalign_o=1 for that cycle. No flush, no PC change.
- While in REQ without acceptance, imem_req_addr may change only on redirect; imem_req_valid stays high.
- Queue: FIFO with wrap-around pointers and explicit count. Simultaneous push and pop when full is legal (credit prevents overflow). Pop only on if_valid&if_ready.
- All arithmetic is XLEN bits, carries discarded.

## Timing
- Request address is registered. First request is issued in the first cycle after rst_n deasserts.
- Response to if_valid: 1 cycle (entry visible the cycle after the rsp_valid edge).
- Redirect to new request: target appears on imem_req_addr the cycle after the redirect. if_valid is 0 that cycle.
- Peak throughput: one instruction per 2 cycles (REQ+WAIT) with a 1-cycle memory.
- if_valid/if_pc/if_instr stay stable while if_ready=0.
- Asynchronous reset mid-transaction: all state clears immediately. A later stale imem_rsp_valid with no outstanding request is ignored.

## Test plan
- Reset, 1-cycle memory, if_ready=1 -> addresses 0x0,0x4,0x8 issued; if_pc sequence 0x0,0x4,0x8 with matching instr.
- if_ready=0, FQ_DEPTH=2 -> exactly 2 entries queued, imem_req_valid drops. Raise if_ready -> fetch resumes at 0x8.
- JAL at ex_pc=0x100, imm=0x10 -> next imem_req_addr=0x120, queue empty; in-flight response for the old address dropped.
- JALR and taken sb in same cycle, iop_a=0x201, imm=0 -> target 0x200 (JALR wins), bit0 cleared.
- sb taken, ex_pc=0x10, imm=1 -> target 0x12, misalign_o pulses, fetch stream unchanged.
- fetch_pc=0xFFFF_FFFC -> next address 0x0. rst_n pulsed in WAIT -> next request at RESET_VECTOR, stale response ignored.

Source files
------------

// File: rtl/ifu_fetch_gen.sv
// Instruction-fetch unit: fetch-PC generation, a single-outstanding
// valid/ready request to instruction memory, and a small FIFO of
// {pc, instr} pairs for the decoders. Redirects from execute flush the
// FIFO and cause an in-flight response to be discarded.
module ifu_fetch_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sb_type,
  input  logic            br_taken,
  input  logic            uj_type,
  input  logic            i_typej,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] iop_a,
  input  logic [XLEN-1:0] imm,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            misalign_o
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            drop_q, drop_d;

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
  logic [31:0]     fq_instr_q [FQ_DEPTH];

  logic [XLEN-1:0] imm_off, jalr_sum, jalr_tgt, br_tgt, redir_tgt;
  logic            redir_req, redir_mis, redir_ok;
  logic            outstanding;
  logic [CW-1:0]   credit;
  logic            accept, rsp_take, push, pop;

  // Redirect target selection: JALR beats JAL beats taken branch.
  assign imm_off   = imm << 1;
  assign jalr_sum  = iop_a + imm_off;
  assign jalr_tgt  = {jalr_sum[XLEN-1:1], 1'b0};
  assign br_tgt    = ex_pc + imm_off;
  assign redir_req = i_typej | uj_type | (sb_type & br_taken);
  assign redir_tgt = i_typej ? jalr_tgt : br_tgt;
  assign redir_mis = redir_req & (redir_tgt[1:0] != 2'b00);
  assign redir_ok  = redir_req & ~redir_mis;

  // Credit counts free FIFO slots not already promised to an in-flight fetch.
  assign outstanding    = (state_q == ST_WAIT);
  assign credit         = CW'(FQ_DEPTH) - count_q - {{(CW-1){1'b0}}, outstanding};
  assign imem_req_valid = rst_n & (state_q == ST_REQ) & (credit != '0);
  assign imem_req_addr  = fetch_pc_q;
  assign misalign_o     = rst_n & redir_mis;

  assign accept   = imem_req_valid & imem_req_ready;
  assign rsp_take = (state_q == ST_WAIT) & imem_rsp_valid;
  assign push     = rsp_take & ~drop_q & ~redir_ok;
  assign pop      = if_valid & if_ready;

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? fq_pc_q[rd_ptr_q]    : '0;
  assign if_instr = if_valid ? fq_instr_q[rd_ptr_q] : '0;

  // Next fetch PC, request state and drop flag.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redir_ok) begin
      fetch_pc_d = redir_tgt;
      if ((state_q == ST_WAIT) && !imem_rsp_valid) begin
        // Response still owed for the old stream: wait for it and bin it.
        state_d = ST_WAIT;
        drop_d  = 1'b1;
      end else if ((state_q == ST_REQ) && accept) begin
        // Memory took an old-stream request this very cycle; it must be binned too.
        state_d = ST_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (accept) begin
            state_d    = ST_WAIT;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end
        default: begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end
        end
      endcase
    end
  end

  // Fetch-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      fetch_pc_q    <= RESET_VECTOR;
      inflight_pc_q <= RESET_VECTOR;
      drop_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      if (accept) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  // FIFO pointers and occupancy; a valid redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redir_ok) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only observable through count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fq_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_gen.sv
// Bench for ifu_fetch_gen: directed steps plus a randomized phase, all
// checked cycle by cycle against a queue-based reference model.
module tb_ifu_fetch_gen;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam int          DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sb_type = 1'b0, br_taken = 1'b0, uj_type = 1'b0, i_typej = 1'b0;
  logic [31:0] ex_pc = '0, iop_a = '0, imm = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc, if_instr;
  logic        misalign_o;

  always #5 clk = ~clk;

  ifu_fetch_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_type(sb_type), .br_taken(br_taken), .uj_type(uj_type), .i_typej(i_typej),
    .ex_pc(ex_pc), .iop_a(iop_a), .imm(imm),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .misalign_o(misalign_o)
  );

  int total = 0;
  int bad   = 0;

  // Environment knobs
  bit   rdy_rand = 0, ifr_rand = 0, lat_rand = 0;
  logic rdy_fix = 1'b1, ifr_fix = 1'b1;
  int   lat_fix = 1;
  bit   inject_stale = 0;

  // Reference model: expected queue contents, next fetch address, and the
  // single outstanding memory request (address, remaining latency, stale?).
  ent_t        q[$];
  logic [31:0] exp_pc = RV;
  bit          busy = 0, stale = 0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;

  // Observation logs taken from the DUT pins
  logic [31:0] acc_log[$];
  ent_t        pop_log[$];
  logic        obs_mis;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_pc = RV;
    busy = 0;
    stale = 0;
    mem_wait = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic cycle(input logic sb, input logic br, input logic uj, input logic ij,
                       input logic [31:0] expc, input logic [31:0] opa, input logic [31:0] immv);
    logic        rsp_this, acc, pop, good, mis, rr;
    logic [31:0] tgt, cur_pc;
    sb_type = sb; br_taken = br; uj_type = uj; i_typej = ij;
    ex_pc = expc; iop_a = opa; imm = immv;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    if_ready       = ifr_rand ? ($urandom_range(0, 2) != 0) : ifr_fix;
    rsp_this = busy && (mem_wait == 0);
    if (rsp_this) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_addr);
    end else if (inject_stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      inject_stale   = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    rr   = ij | uj | (sb & br);
    tgt  = ij ? ((opa + (immv << 1)) & ~32'h1) : (expc + (immv << 1));
    mis  = rr && (tgt[1:0] != 2'b00);
    good = rr && !mis;

    @(negedge clk);
    chk("req_valid", imem_req_valid, (!busy && q.size() < DEPTH));
    chk("req_addr", imem_req_addr, exp_pc);
    chk("if_valid", if_valid, (q.size() > 0));
    chk("if_pc", if_pc, (q.size() > 0) ? q[0].pc : 32'h0);
    chk("if_instr", if_instr, (q.size() > 0) ? q[0].ins : 32'h0);
    chk("misalign", misalign_o, mis);
    obs_mis = misalign_o;
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
    if (if_valid && if_ready) begin
      pop_log.push_back('{if_pc, if_instr});
      $display("pop pc=%08h instr=%08h", if_pc, if_instr);
    end
    acc    = !busy && (q.size() < DEPTH) && imem_req_ready;
    pop    = (q.size() > 0) && if_ready;
    cur_pc = exp_pc;

    @(posedge clk);
    #1;
    if (good) begin
      q.delete();
      if (acc) stale = 1;
      else if (rsp_this) stale = 0;
      else if (busy) stale = 1;
      exp_pc = tgt;
    end else begin
      if (pop) void'(q.pop_front());
      if (rsp_this && !stale) q.push_back('{mem_addr, instr_of(mem_addr)});
      if (rsp_this) stale = 0;
      if (acc) exp_pc = cur_pc + 32'd4;
    end
    if (rsp_this) busy = 0;
    else if (busy && mem_wait > 0) mem_wait--;
    if (acc) begin
      busy     = 1;
      mem_addr = cur_pc;
      mem_wait = (lat_rand ? int'($urandom_range(1, 3)) : lat_fix) - 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Reset with a misaligned branch pending on the inputs: every output must still be quiet.
  task automatic do_reset();
    rst_n = 1'b0;
    sb_type = 1'b1; br_taken = 1'b1; uj_type = 1'b0; i_typej = 1'b0;
    ex_pc = 32'h10; imm = 32'h1; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RV);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_misalign", misalign_o, 1'b0);
    @(posedge clk);
    #1;
    sb_type = 1'b0; br_taken = 1'b0;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic wait_inflight();
    for (int i = 0; i < 10 && !(busy && mem_wait > 0); i++) idle(1);
  endtask

  initial begin
    bit found;
    logic [31:0] r;

    // Step 1: straight-line fetch with a 1-cycle memory
    do_reset();
    rdy_fix = 1'b1; ifr_fix = 1'b1; lat_fix = 1;
    pop_log.delete();
    idle(8);
    chk("seq_pop_count", (pop_log.size() >= 3), 1'b1);
    if (pop_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", pop_log[i].pc, 32'(4 * i));
        chk("seq_instr", pop_log[i].ins, instr_of(32'(4 * i)));
      end
    end

    // Step 2: decoder stalls, queue fills and requests stop
    ifr_fix = 1'b0;
    idle(10);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_if_valid", if_valid, 1'b1);
    ifr_fix = 1'b1;
    idle(6);

    // Step 3: JAL while a response is still in flight
    lat_fix = 3;
    wait_inflight();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h10);
    chk("jal_addr", imem_req_addr, 32'h120);
    chk("jal_flush", if_valid, 1'b0);
    idle(10);

    // Step 4: JALR and taken branch together, JALR wins and bit 0 is cleared
    lat_fix = 1;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h201, 32'h0);
    chk("jalr_addr", imem_req_addr, 32'h200);
    idle(4);

    // Step 5: misaligned taken branch only pulses misalign_o
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1);
    chk("misalign_pulse", obs_mis, 1'b1);
    idle(4);

    // Step 6: fetch PC wraps from the top of the address space
    acc_log.delete();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    idle(8);
    found = 0;
    for (int i = 0; i + 1 < acc_log.size(); i++)
      if (acc_log[i] == 32'hFFFF_FFFC && acc_log[i+1] == 32'h0) found = 1;
    chk("pc_wrap", found, 1'b1);

    // Step 7: reset mid-WAIT, then a stale response arrives and is ignored
    lat_fix = 3;
    wait_inflight();
    do_reset();
    rdy_fix = 1'b0;
    inject_stale = 1;
    idle(3);
    chk("stale_ignored", if_valid, 1'b0);
    acc_log.delete();
    rdy_fix = 1'b1;
    lat_fix = 1;
    idle(4);
    chk("post_reset_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RV);

    // Step 8: randomized traffic, latencies and redirects
    rdy_rand = 1; ifr_rand = 1; lat_rand = 1;
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        cycle(r[0], r[1], r[2], r[3], $urandom & ~32'h3, $urandom,
              {{23{r[16]}}, r[16:8]});
      end else begin
        idle(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
